neural_seq: RTL and testbench

//  Sequencer that drives the 20-lane MAC neuron over a layer: issues input/weight memory reads chunk by chunk.

---
 rtl/neural_pkg.sv | 29 ++
 rtl/neural_seq_addr_gen.sv | 50 +++++
 rtl/neural_seq.sv | 164 ++++++++++++++++
 tb/tb_neural_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
// Shared types and helpers for the neuron sequencer.
// Optional feature macro: NEURAL_SEQ_BIAS_EN (adds the bias step to every neuron).
package neural_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned LANES = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Bit width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned w_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Read steps per neuron: regular chunks, plus the bias step when enabled.
    function automatic int unsigned steps_of(input int unsigned num_chunks);
`ifdef NEURAL_SEQ_BIAS_EN
        return num_chunks + 1;
`else
        return num_chunks;
`endif
    endfunction

endpackage

// File: rtl/neural_seq_addr_gen.sv
// Chunk/neuron counter pair for the neuron sequencer.
// Step count per neuron depends on NEURAL_SEQ_BIAS_EN through neural_pkg::steps_of.
module neural_seq_addr_gen #(
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_NEURONS = 8
) (
    input  logic                                                              clk,
    input  logic                                                              rst,
    input  logic                                                              clear,
    input  logic                                                              step,
    output logic [neural_pkg::w_of(neural_pkg::steps_of(NUM_CHUNKS))-1:0]     c,
    output logic [neural_pkg::w_of(NUM_NEURONS)-1:0]                          j,
    output logic [neural_pkg::w_of(NUM_NEURONS*neural_pkg::steps_of(NUM_CHUNKS))-1:0] w,
    output logic                                                              last_chunk,
    output logic                                                              last_neuron
);
    import neural_pkg::*;

    localparam int unsigned S  = steps_of(NUM_CHUNKS);
    localparam int unsigned CW = w_of(S);
    localparam int unsigned JW = w_of(NUM_NEURONS);

    assign last_chunk  = (c == CW'(S - 1));
    assign last_neuron = (j == JW'(NUM_NEURONS - 1));

    // Weight address j*S+c advances by one per step, so it is kept as a plain
    // linear counter instead of being multiplied out.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            c <= '0;
            j <= '0;
            w <= '0;
        end else if (step) begin
            if (last_chunk) begin
                c <= '0;
                if (last_neuron) begin
                    j <= '0;
                    w <= '0;
                end else begin
                    j <= j + 1'b1;
                    w <= w + 1'b1;
                end
            end else begin
                c <= c + 1'b1;
                w <= w + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neural_seq.sv
// Layer sequencer for the 20-lane MAC neuron: issues ROM reads, aligns the
// neuron controls with returning data and streams out finished sums.
// Optional feature macro: NEURAL_SEQ_BIAS_EN (bias step per neuron, drives n_isbias).
module neural_seq #(
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_NEURONS = 8,
    parameter int DW          = neural_pkg::DW
) (
    input  logic                                                                      clk,
    input  logic                                                                      rst,
    input  logic                                                                      start,
    output logic                                                                      busy,
    output logic                                                                      done,
    output logic                                                                      mem_rd,
    output logic [neural_pkg::w_of(neural_pkg::steps_of(NUM_CHUNKS))-1:0]             in_addr,
    output logic [neural_pkg::w_of(NUM_NEURONS*neural_pkg::steps_of(NUM_CHUNKS))-1:0] w_addr,
    output logic                                                                      n_zero,
    output logic                                                                      n_isbias,
    output logic [DW-1:0]                                                             n_last_data,
    input  logic [DW-1:0]                                                             n_out,
    output logic                                                                      res_valid,
    output logic [DW-1:0]                                                             res_data,
    output logic [neural_pkg::w_of(NUM_NEURONS)-1:0]                                  res_idx
);
    import neural_pkg::*;

    localparam int unsigned S  = steps_of(NUM_CHUNKS);
    localparam int unsigned CW = w_of(S);
    localparam int unsigned JW = w_of(NUM_NEURONS);
    localparam int unsigned WW = w_of(NUM_NEURONS * S);

    seq_state_t state_q, state_d;

    logic          step, clear;
    logic [CW-1:0] c;
    logic [JW-1:0] j;
    logic [WW-1:0] w;
    logic          last_chunk, last_neuron;

    // Issue-stage tags travelling alongside each read
    logic          iss_first, iss_last;
    logic [JW-1:0] iss_j;
    // Data-stage tags
    logic          dat_valid, dat_last;
    logic [JW-1:0] dat_j;
    logic [DW-1:0] res_hold;

    neural_seq_addr_gen #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .NUM_NEURONS(NUM_NEURONS)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .step       (step),
        .c          (c),
        .j          (j),
        .w          (w),
        .last_chunk (last_chunk),
        .last_neuron(last_neuron)
    );

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Next-state logic and counter control
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                step = 1'b1;
                if (last_chunk && last_neuron) state_d = DRAIN;
            end
            DRAIN: begin
                if (res_valid && (res_idx == JW'(NUM_NEURONS - 1))) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Issue stage: read strobe, addresses and step tags for the data cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd    <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            iss_first <= 1'b0;
            iss_last  <= 1'b0;
            iss_j     <= '0;
        end else begin
            mem_rd    <= (state_q == ISSUE);
            in_addr   <= c;
            w_addr    <= w;
            iss_first <= (c == '0);
            iss_last  <= last_chunk;
            iss_j     <= j;
        end
    end

    // Data stage: neuron controls line up with the ROM data returning this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            n_zero    <= 1'b0;
            dat_valid <= 1'b0;
            dat_last  <= 1'b0;
            dat_j     <= '0;
        end else begin
            n_zero    <= mem_rd && iss_first;
            dat_valid <= mem_rd;
            dat_last  <= mem_rd && iss_last;
            dat_j     <= iss_j;
        end
    end

`ifdef NEURAL_SEQ_BIAS_EN
    logic iss_bias;

    // Bias-step tag and its aligned neuron control
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_bias <= 1'b0;
            n_isbias <= 1'b0;
        end else begin
            iss_bias <= (c == CW'(NUM_CHUNKS));
            n_isbias <= mem_rd && iss_bias;
        end
    end
`else
    assign n_isbias = 1'b0;
`endif

    assign n_last_data = dat_valid ? n_out : '0;

    // Result capture: valid the cycle after the final data cycle of a neuron
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_hold  <= '0;
        end else begin
            res_valid <= dat_last;
            if (dat_last)  res_idx  <= dat_j;
            if (res_valid) res_hold <= n_out;
        end
    end

    // The neuron's registered sum only appears in the result cycle itself, so
    // that cycle forwards n_out directly and the holding register keeps it after.
    assign res_data = res_valid ? n_out : res_hold;

endmodule

// File: tb/tb_neural_seq.sv
// Self-checking bench for neural_seq with a behavioural neuron and ROMs.
// Works with NEURAL_SEQ_BIAS_EN defined or undefined.
module tb_neural_seq;
    import neural_pkg::*;

    localparam int NC   = 2;
    localparam int NN   = 3;
    localparam int S    = steps_of(NC);
    localparam int CW   = w_of(S);
    localparam int JW   = w_of(NN);
    localparam int WW   = w_of(NN * S);
    localparam int L    = LANES;
    localparam bit BIAS = (S == NC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, mem_rd, n_zero, n_isbias, res_valid;
    logic [CW-1:0] in_addr;
    logic [WW-1:0] w_addr;
    logic [7:0]    n_last_data, n_out, res_data;
    logic [JW-1:0] res_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] in_rom [S][L];
    logic [7:0] w_rom  [NN*S][L];
    logic [7:0] exp_res [NN];

    neural_seq #(
        .NUM_CHUNKS (NC),
        .NUM_NEURONS(NN),
        .DW         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .in_addr    (in_addr),
        .w_addr     (w_addr),
        .n_zero     (n_zero),
        .n_isbias   (n_isbias),
        .n_last_data(n_last_data),
        .n_out      (n_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx)
    );

    always #5 clk = ~clk;

    // ROMs: data valid the cycle after the read strobe
    logic          rd_q = 1'b0;
    logic [CW-1:0] a_in = '0;
    logic [WW-1:0] a_w  = '0;
    always @(posedge clk) begin
        rd_q <= mem_rd;
        a_in <= in_addr;
        a_w  <= w_addr;
    end

    // Neuron stand-in: 20-lane MAC with accumulator feedback, 8-bit wrap
    logic [7:0] acc_next;
    always @* begin
        int acc;
        acc = n_zero ? 0 : int'(n_last_data);
        for (int l = 0; l < L; l++)
            if (!n_isbias || l == 0)
                acc += int'(in_rom[a_in][l]) * int'(w_rom[a_w][l]);
        acc_next = acc[7:0];
    end

    always @(posedge clk) begin
        if (rst)       n_out <= 8'h00;
        else if (rd_q) n_out <= acc_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sum of neuron j straight from the ROM contents
    task automatic model_all();
        for (int jj = 0; jj < NN; jj++) begin
            int acc;
            acc = 0;
            for (int c = 0; c < S; c++)
                for (int l = 0; l < L; l++)
                    if (c != NC || l == 0)
                        acc += int'(in_rom[c][l]) * int'(w_rom[jj*S + c][l]);
            exp_res[jj] = 8'(acc % 256);
        end
    endtask

    task automatic fill_bias_entry();
        for (int c = 0; c < S; c++)
            if (c == NC)
                for (int l = 0; l < L; l++) in_rom[c][l] = (l == 0) ? 8'h01 : 8'h00;
    endtask

    task automatic fill_random();
        for (int c = 0; c < S; c++)
            for (int l = 0; l < L; l++) in_rom[c][l] = 8'($urandom_range(0, 255));
        for (int a = 0; a < NN*S; a++)
            for (int l = 0; l < L; l++) w_rom[a][l] = 8'($urandom_range(0, 255));
        fill_bias_entry();
        model_all();
    endtask

    // All-ones chunks (sum 0x14 each) plus bias 0x05
    task automatic fill_ones();
        for (int c = 0; c < S; c++)
            for (int l = 0; l < L; l++) in_rom[c][l] = 8'h01;
        for (int a = 0; a < NN*S; a++)
            for (int l = 0; l < L; l++) w_rom[a][l] = ((a % S) == NC && l == 0) ? 8'h05 : 8'h01;
        fill_bias_entry();
        for (int jj = 0; jj < NN; jj++) exp_res[jj] = BIAS ? 8'h2D : 8'h28;
    endtask

    // Chunk sums 0xF0 and 0x20, bias 0: wraps to 0x10
    task automatic fill_wrap();
        for (int c = 0; c < S; c++)
            for (int l = 0; l < L; l++) in_rom[c][l] = (l == 0) ? 8'h01 : 8'h00;
        for (int a = 0; a < NN*S; a++)
            for (int l = 0; l < L; l++)
                w_rom[a][l] = (l != 0) ? 8'h00 : ((a % S) == 0) ? 8'hF0 : ((a % S) == 1) ? 8'h20 : 8'h00;
        for (int jj = 0; jj < NN; jj++) exp_res[jj] = 8'h10;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_n_zero"}, 32'(n_zero), 0);
        chk({tag, "_n_isbias"}, 32'(n_isbias), 0);
    endtask

    // One layer; cycle 0 is the start-accept edge. Optional extra start pulses
    // at s1/s2 and an optional reset pulse at rst_cyc.
    task automatic run_layer(input int s1, input int s2, input int rst_cyc);
        int last, nres, ndone;
        last  = NN*S + 3;
        nres  = 0;
        ndone = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= last + 1; k++) begin
            bit exp_rd, dv, rv;
            int dt, rj;
            if (k > 0) tick();
            cyc    = k;
            exp_rd = (k >= 1 && k <= NN*S);
            chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
            if (exp_rd) begin
                chk("in_addr", 32'(in_addr), 32'((k-1) % S));
                chk("w_addr", 32'(w_addr), 32'(k-1));
            end
            dt = k - 2;
            dv = (dt >= 0 && dt < NN*S);
            chk("n_zero", 32'(n_zero), 32'(dv && (dt % S) == 0));
            chk("n_isbias", 32'(n_isbias), 32'(dv && BIAS && (dt % S) == NC));
            chk("n_last_data", 32'(n_last_data), dv ? 32'(n_out) : 32'd0);
            rv = (k >= S + 2) && ((k - 2) % S == 0) && ((k - 2) / S - 1 < NN);
            chk("res_valid", 32'(res_valid), 32'(rv));
            if (rv) begin
                rj = (k - 2) / S - 1;
                chk("res_idx", 32'(res_idx), 32'(rj));
                chk("res_data", 32'(res_data), 32'(exp_res[rj]));
            end
            chk("done", 32'(done), 32'(k == last));
            chk("busy", 32'(busy), 32'(k <= last));
            if (res_valid) nres++;
            if (done) ndone++;
            if (k == rst_cyc) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                cyc = k + 1;
                chk_idle("after_rst");
                chk("after_rst_in_addr", 32'(in_addr), 0);
                chk("after_rst_w_addr", 32'(w_addr), 0);
                chk("after_rst_res_data", 32'(res_data), 0);
                chk("after_rst_res_idx", 32'(res_idx), 0);
                chk("after_rst_last_data", 32'(n_last_data), 0);
                for (int q = 0; q < 15; q++) begin
                    tick();
                    cyc = k + 2 + q;
                    chk_idle("aborted");
                end
                return;
            end
            start = (k == s1 || k == s2);
        end
        start = 1'b0;
        chk("res_count", 32'(nres), NN);
        chk("done_count", 32'(ndone), 1);
    endtask

    // Hard stop if the sequence above ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        cyc = 0;
        chk_idle("reset");
        chk("reset_in_addr", 32'(in_addr), 0);
        chk("reset_w_addr", 32'(w_addr), 0);
        chk("reset_res_data", 32'(res_data), 0);
        chk("reset_res_idx", 32'(res_idx), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        fill_ones();
        run_layer(-1, -1, -1);

        fill_random();
        run_layer(3, NN*S + 3, -1);

        fill_wrap();
        run_layer(-1, -1, -1);

        fill_random();
        run_layer(-1, -1, 6);
        fill_ones();
        run_layer(-1, -1, -1);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_layer(-1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
